// File: rtl/hash_table_v3.sv
// Bucketed hash table for one join partition: BUILD inserts tuples into hash-selected rows,
// PROBE compares a probe key against every valid slot of its row and streams the results.
module hash_table_v3 #(
    parameter int TUPLE_SIZE = 64,
    parameter int KEY_BITS   = 32,
    parameter int ROW_BITS   = 3,
    parameter int COL_BITS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    in_ready_BUILD,
    input  logic [TUPLE_SIZE-1:0]   in_data_BUILD,
    input  logic [31:0]             in_hash_BUILD,
    input  logic                    in_valid_BUILD,
    input  logic                    in_last_processed_BUILD,
    output logic                    in_ready_PROBE,
    input  logic [TUPLE_SIZE-1:0]   in_data_PROBE,
    input  logic [31:0]             in_hash_PROBE,
    input  logic                    in_valid_PROBE,
    input  logic                    in_last_processed_PROBE,
    input  logic [63:0]             in_serialnum,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2*TUPLE_SIZE-1:0] out_data,
    output logic                    out_last_processed,
    output logic [63:0]             out_serialnum,
    output logic                    out_was_joined,
    output logic [31:0]             out_overflow_cnt
);
    localparam int ROWS  = 1 << ROW_BITS;
    localparam int SLOTS = 1 << COL_BITS;
    localparam logic [COL_BITS:0] FULL = {1'b1, {COL_BITS{1'b0}}};

    typedef enum logic [1:0] {BUILD, P_IDLE, P_READ, P_EMIT} state_t;

    state_t                state;
    logic [TUPLE_SIZE-1:0] mem      [ROWS][SLOTS];
    logic [COL_BITS:0]     fill     [ROWS];
    logic [TUPLE_SIZE-1:0] row_data [SLOTS];
    logic [TUPLE_SIZE-1:0] p_tuple;
    logic [63:0]           p_serial;
    logic                  p_last;
    logic [ROW_BITS-1:0]   p_row;
    logic [SLOTS-1:0]      pending;

    logic [ROW_BITS-1:0]   build_row;
    logic                  build_accept;
    logic                  build_room;
    logic [SLOTS-1:0]      match_vec;
    logic [COL_BITS-1:0]   first_slot;
    logic [SLOTS-1:0]      first_rest;
    logic [COL_BITS-1:0]   next_slot;
    logic [SLOTS-1:0]      next_rest;
    logic                  unused_hash_bits;

    function automatic logic [COL_BITS-1:0] lowest_set(input logic [SLOTS-1:0] v);
        logic [COL_BITS-1:0] idx;
        idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (v[i]) idx = COL_BITS'(i);
        return idx;
    endfunction

    assign in_ready_BUILD   = (state == BUILD);
    assign in_ready_PROBE   = (state == P_IDLE);
    assign build_row        = in_hash_BUILD[ROW_BITS-1:0];
    assign build_accept     = in_valid_BUILD && (state == BUILD);
    assign build_room       = fill[build_row] < FULL;
    assign unused_hash_bits = ^{in_hash_BUILD[31:ROW_BITS], in_hash_PROBE[31:ROW_BITS]};

    // Slot s takes part in a match only if it has been filled in this partition.
    always_comb begin
        match_vec = '0;
        for (int s = 0; s < SLOTS; s++)
            match_vec[s] = ((COL_BITS+1)'(s) < fill[p_row]) &&
                           (mem[p_row][s][KEY_BITS-1:0] == p_tuple[KEY_BITS-1:0]);
        first_slot             = lowest_set(match_vec);
        first_rest             = match_vec;
        first_rest[first_slot] = 1'b0;
        next_slot              = lowest_set(pending);
        next_rest              = pending;
        next_rest[next_slot]   = 1'b0;
    end

    // Data array has no reset so it can map onto block RAM; the fill counters define validity.
    always_ff @(posedge clk) begin
        if (!reset && build_accept && build_room)
            mem[build_row][fill[build_row][COL_BITS-1:0]] <= in_data_BUILD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= BUILD;
            for (int r = 0; r < ROWS; r++) fill[r] <= '0;
            out_overflow_cnt   <= '0;
            out_valid          <= 1'b0;
            out_data           <= '0;
            out_last_processed <= 1'b0;
            out_serialnum      <= '0;
            out_was_joined     <= 1'b0;
            p_tuple            <= '0;
            p_serial           <= '0;
            p_last             <= 1'b0;
            p_row              <= '0;
            pending            <= '0;
        end else begin
            case (state)
                BUILD: begin
                    if (build_accept) begin
                        if (build_room)
                            fill[build_row] <= fill[build_row] + 1'b1;
                        else if (out_overflow_cnt != 32'hFFFF_FFFF)
                            out_overflow_cnt <= out_overflow_cnt + 32'd1;
                        if (in_last_processed_BUILD)
                            state <= P_IDLE;
                    end
                end
                P_IDLE: begin
                    if (in_valid_PROBE) begin
                        p_tuple  <= in_data_PROBE;
                        p_serial <= in_serialnum;
                        p_last   <= in_last_processed_PROBE;
                        p_row    <= in_hash_PROBE[ROW_BITS-1:0];
                        state    <= P_READ;
                    end
                end
                P_READ: begin
                    for (int s = 0; s < SLOTS; s++) row_data[s] <= mem[p_row][s];
                    out_valid     <= 1'b1;
                    out_serialnum <= p_serial;
                    if (|match_vec) begin
                        out_data           <= {mem[p_row][first_slot], p_tuple};
                        out_was_joined     <= 1'b1;
                        pending            <= first_rest;
                        out_last_processed <= p_last && (first_rest == '0);
                    end else begin
                        out_data           <= {{TUPLE_SIZE{1'b0}}, p_tuple};
                        out_was_joined     <= 1'b0;
                        pending            <= '0;
                        out_last_processed <= p_last;
                    end
                    state <= P_EMIT;
                end
                P_EMIT: begin
                    if (out_ready) begin
                        if (|pending) begin
                            out_data           <= {row_data[next_slot], p_tuple};
                            pending            <= next_rest;
                            out_last_processed <= p_last && (next_rest == '0);
                        end else begin
                            out_valid          <= 1'b0;
                            out_last_processed <= 1'b0;
                            out_was_joined     <= 1'b0;
                            if (p_last) begin
                                state <= BUILD;
                                for (int r = 0; r < ROWS; r++) fill[r] <= '0;
                            end else begin
                                state <= P_IDLE;
                            end
                        end
                    end
                end
                default: state <= BUILD;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_table_v3.sv
// Randomised and directed checks of hash_table_v3 against a queue-per-row model of the table.
module tb_hash_table_v3;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_ready_BUILD, in_ready_PROBE;
    logic [63:0]  in_data_BUILD, in_data_PROBE;
    logic [31:0]  in_hash_BUILD, in_hash_PROBE;
    logic         in_valid_BUILD, in_valid_PROBE;
    logic         in_last_processed_BUILD, in_last_processed_PROBE;
    logic [63:0]  in_serialnum;
    logic         out_ready, out_valid, out_last_processed, out_was_joined;
    logic [127:0] out_data;
    logic [63:0]  out_serialnum;
    logic [31:0]  out_overflow_cnt;

    int errors = 0;
    int checks = 0;

    logic [63:0]  mdl_rows [8][$];
    int unsigned  mdl_overflow;
    logic [127:0] exp_data [$];
    logic         exp_joined [$];
    logic         exp_last [$];
    logic [127:0] cap_data [$];
    logic [63:0]  cap_serial [$];
    logic         cap_joined [$];
    logic         cap_last [$];
    int           cap_latency;
    bit           cap_stable;

    always #5 clk = ~clk;

    hash_table_v3 dut (
        .clk(clk), .reset(reset),
        .in_ready_BUILD(in_ready_BUILD), .in_data_BUILD(in_data_BUILD),
        .in_hash_BUILD(in_hash_BUILD), .in_valid_BUILD(in_valid_BUILD),
        .in_last_processed_BUILD(in_last_processed_BUILD),
        .in_ready_PROBE(in_ready_PROBE), .in_data_PROBE(in_data_PROBE),
        .in_hash_PROBE(in_hash_PROBE), .in_valid_PROBE(in_valid_PROBE),
        .in_last_processed_PROBE(in_last_processed_PROBE), .in_serialnum(in_serialnum),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last_processed(out_last_processed), .out_serialnum(out_serialnum),
        .out_was_joined(out_was_joined), .out_overflow_cnt(out_overflow_cnt)
    );

    function automatic logic [63:0] make_tuple(input logic [31:0] key);
        return {$urandom(), key};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) mdl_rows[r].delete();
        mdl_overflow = 0;
    endtask

    // Each row keeps at most two tuples in arrival order; extra tuples only bump the drop count.
    task automatic model_probe(input logic [63:0] tuple, input logic [31:0] hash, input logic last);
        int r;
        r = int'(hash[2:0]);
        exp_data.delete(); exp_joined.delete(); exp_last.delete();
        for (int i = 0; i < mdl_rows[r].size(); i++) begin
            if (mdl_rows[r][i][31:0] == tuple[31:0]) begin
                exp_data.push_back({mdl_rows[r][i], tuple});
                exp_joined.push_back(1'b1);
                exp_last.push_back(1'b0);
            end
        end
        if (exp_data.size() == 0) begin
            exp_data.push_back({64'd0, tuple});
            exp_joined.push_back(1'b0);
            exp_last.push_back(1'b0);
        end
        exp_last[exp_last.size()-1] = last;
        if (last) for (int k = 0; k < 8; k++) mdl_rows[k].delete();
    endtask

    task automatic drive_build(input logic [63:0] tuple, input logic [31:0] hash, input logic last);
        int n;
        int r;
        r = int'(hash[2:0]);
        if (mdl_rows[r].size() < 2) mdl_rows[r].push_back(tuple);
        else mdl_overflow++;
        in_data_BUILD = tuple; in_hash_BUILD = hash;
        in_last_processed_BUILD = last; in_valid_BUILD = 1'b1;
        n = 0;
        while (!in_ready_BUILD && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            errors++; checks++;
            $display("[TB] FAIL build_timeout: in_ready_BUILD=%b, required 1", in_ready_BUILD);
        end
        @(posedge clk); #1;
        in_valid_BUILD = 1'b0; in_last_processed_BUILD = 1'b0;
    endtask

    task automatic send_probe(input logic [63:0] tuple, input logic [31:0] hash,
                              input logic [63:0] serial, input logic last);
        int n;
        in_data_PROBE = tuple; in_hash_PROBE = hash; in_serialnum = serial;
        in_last_processed_PROBE = last; in_valid_PROBE = 1'b1;
        n = 0;
        while (!in_ready_PROBE && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            errors++; checks++;
            $display("[TB] FAIL probe_timeout: in_ready_PROBE=%b, required 1", in_ready_PROBE);
        end
        @(posedge clk); #1;
        in_valid_PROBE = 1'b0; in_last_processed_PROBE = 1'b0;
    endtask

    // Captures every accepted beat; out_ready is held low for 'stall' cycles on the first beat.
    task automatic run_probe(input logic [63:0] tuple, input logic [31:0] hash,
                             input logic [63:0] serial, input logic last, input int stall);
        int cyc, held;
        logic [127:0] snap_d;
        logic [63:0]  snap_s;
        logic         snap_j;
        model_probe(tuple, hash, last);
        send_probe(tuple, hash, serial, last);
        cap_data.delete(); cap_serial.delete(); cap_joined.delete(); cap_last.delete();
        cap_latency = -1; cap_stable = 1'b1; held = 0; cyc = 1;
        snap_d = '0; snap_s = '0; snap_j = 1'b0;
        out_ready = (stall == 0);
        while (cyc < 200) begin
            if (out_valid) begin
                if (cap_latency < 0) cap_latency = cyc;
                if (!out_ready) begin
                    if (held == 0) begin
                        snap_d = out_data; snap_s = out_serialnum; snap_j = out_was_joined;
                    end else if (out_data !== snap_d || out_serialnum !== snap_s ||
                                 out_was_joined !== snap_j) begin
                        cap_stable = 1'b0;
                    end
                    held++;
                    if (held > stall) out_ready = 1'b1;
                end
                if (out_ready) begin
                    cap_data.push_back(out_data); cap_serial.push_back(out_serialnum);
                    cap_joined.push_back(out_was_joined); cap_last.push_back(out_last_processed);
                end
            end else if (cap_data.size() > 0) begin
                break;
            end
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 200) begin
            errors++; checks++;
            $display("[TB] FAIL emit_timeout: out_valid=%b after %0d cycles, required 0", out_valid, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_last_processed, out_was_joined, in_ready_BUILD, in_ready_PROBE} !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL reset_flags: got v/l/j/rb/rp=%b, required 00010",
                     {out_valid, out_last_processed, out_was_joined, in_ready_BUILD, in_ready_PROBE});
        end
        checks++;
        if (out_data !== 128'd0 || out_serialnum !== 64'd0 || out_overflow_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got data=%h serial=%h ovf=%0d, required zeros",
                     out_data, out_serialnum, out_overflow_cnt);
        end
    endtask

    task automatic test_basic_join();
        drive_build(make_tuple(32'd5), 32'd1, 1'b0);
        drive_build(make_tuple(32'd9), 32'd1, 1'b0);
        drive_build(make_tuple(32'd12), 32'd4, 1'b1);
        run_probe(make_tuple(32'd9), 32'd1, 64'd7, 1'b1, 0);
        checks++;
        if (cap_latency !== 2) begin
            errors++; $display("[TB] FAIL basic_latency: got %0d, required 2", cap_latency);
        end
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++; $display("[TB] FAIL basic_beats: got %0d, required %0d", cap_data.size(), exp_data.size());
        end else foreach (exp_data[i]) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_joined[i] !== exp_joined[i] ||
                cap_last[i] !== exp_last[i] || cap_serial[i] !== 64'd7) begin
                errors++;
                $display("[TB] FAIL basic_beat%0d: got %h j=%b l=%b s=%0d, required %h j=%b l=%b s=7",
                         i, cap_data[i], cap_joined[i], cap_last[i], cap_serial[i],
                         exp_data[i], exp_joined[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_duplicates();
        drive_build(make_tuple(32'd3), 32'd2, 1'b0);
        drive_build(make_tuple(32'd3), 32'h0000_0102, 1'b1);
        run_probe(make_tuple(32'd3), 32'd2, 64'd11, 1'b1, 0);
        checks++;
        if (cap_data.size() != 2 || exp_data.size() != 2) begin
            errors++; $display("[TB] FAIL dup_beats: got %0d, required 2", cap_data.size());
        end else foreach (exp_data[i]) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_joined[i] !== exp_joined[i] ||
                cap_last[i] !== exp_last[i] || cap_serial[i] !== 64'd11) begin
                errors++;
                $display("[TB] FAIL dup_beat%0d: got %h j=%b l=%b s=%0d, required %h j=%b l=%b s=11",
                         i, cap_data[i], cap_joined[i], cap_last[i], cap_serial[i],
                         exp_data[i], exp_joined[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_miss();
        drive_build(make_tuple(32'd1), 32'd0, 1'b1);
        run_probe(make_tuple(32'd77), 32'd6, 64'd21, 1'b1, 0);
        checks++;
        if (cap_data.size() != 1) begin
            errors++; $display("[TB] FAIL miss_beats: got %0d, required 1", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== exp_data[0] || cap_joined[0] !== 1'b0 || cap_last[0] !== 1'b1 ||
                cap_data[0][127:64] !== 64'd0) begin
                errors++;
                $display("[TB] FAIL miss_beat: got %h j=%b l=%b, required %h j=0 l=1",
                         cap_data[0], cap_joined[0], cap_last[0], exp_data[0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] t11;
        t11 = make_tuple(32'd11);
        drive_build(make_tuple(32'd10), 32'd0, 1'b0);
        drive_build(t11, 32'd8, 1'b0);
        drive_build(make_tuple(32'd12), 32'd16, 1'b1);
        checks++;
        if (out_overflow_cnt !== 32'd1 || mdl_overflow != 1) begin
            errors++; $display("[TB] FAIL overflow_cnt: got %0d, required 1", out_overflow_cnt);
        end
        run_probe(make_tuple(32'd11), 32'd0, 64'd30, 1'b0, 0);
        checks++;
        if (cap_data.size() != 1 || cap_joined[0] !== 1'b1 || cap_data[0][127:64] !== t11 ||
            cap_data[0] !== exp_data[0]) begin
            errors++; $display("[TB] FAIL overflow_hit: got beats=%0d, required 1 joined beat with %h",
                               cap_data.size(), t11);
        end
        run_probe(make_tuple(32'd12), 32'd0, 64'd31, 1'b1, 0);
        checks++;
        if (cap_data.size() != 1 || cap_joined[0] !== 1'b0 || cap_data[0] !== exp_data[0]) begin
            errors++; $display("[TB] FAIL overflow_drop: got beats=%0d, required 1 miss beat", cap_data.size());
        end
    endtask

    task automatic test_backpressure();
        drive_build(make_tuple(32'd3), 32'd5, 1'b0);
        drive_build(make_tuple(32'd3), 32'd5, 1'b1);
        run_probe(make_tuple(32'd3), 32'd5, 64'd99, 1'b1, 5);
        checks++;
        if (cap_stable !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_stable: got %b, required 1", cap_stable);
        end
        checks++;
        if (cap_data.size() != 2) begin
            errors++; $display("[TB] FAIL stall_beats: got %0d, required 2", cap_data.size());
        end else foreach (exp_data[i]) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_joined[i] !== exp_joined[i] ||
                cap_last[i] !== exp_last[i] || cap_serial[i] !== 64'd99) begin
                errors++;
                $display("[TB] FAIL stall_beat%0d: got %h j=%b l=%b s=%0d, required %h j=%b l=%b s=99",
                         i, cap_data[i], cap_joined[i], cap_last[i], cap_serial[i],
                         exp_data[i], exp_joined[i], exp_last[i]);
            end
        end
        checks++;
        if (in_ready_BUILD !== 1'b1 || in_ready_PROBE !== 1'b0) begin
            errors++; $display("[TB] FAIL back_to_build: got rb=%b rp=%b, required 1 0", in_ready_BUILD, in_ready_PROBE);
        end
        drive_build(make_tuple(32'd20), 32'd5, 1'b1);
        run_probe(make_tuple(32'd3), 32'd5, 64'd100, 1'b0, 0);
        checks++;
        if (cap_data.size() != 1 || cap_joined[0] !== 1'b0 || cap_data[0] !== exp_data[0]) begin
            errors++; $display("[TB] FAIL fill_cleared_old: got beats=%0d, required 1 miss beat", cap_data.size());
        end
        run_probe(make_tuple(32'd20), 32'd5, 64'd101, 1'b1, 0);
        checks++;
        if (cap_data.size() != 1 || cap_joined[0] !== 1'b1 || cap_data[0] !== exp_data[0] ||
            out_overflow_cnt !== mdl_overflow) begin
            errors++; $display("[TB] FAIL fill_cleared_new: got beats=%0d ovf=%0d, required 1 hit ovf=%0d",
                               cap_data.size(), out_overflow_cnt, mdl_overflow);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                logic [31:0] h;
                h = $urandom();
                h[2:0] = 3'($urandom_range(0, 3));
                drive_build(make_tuple(32'($urandom_range(0, 5))), h, b == nb - 1);
            end
            checks++;
            if (out_overflow_cnt !== mdl_overflow) begin
                errors++; $display("[TB] FAIL rand_overflow: got %0d, required %0d", out_overflow_cnt, mdl_overflow);
            end
            for (int p = 0; p < 4; p++) begin
                logic [31:0] h;
                logic [63:0] ser;
                h = $urandom();
                h[2:0] = 3'($urandom_range(0, 3));
                ser = {$urandom(), $urandom()};
                run_probe(make_tuple(32'($urandom_range(0, 5))), h, ser, p == 3, $urandom_range(0, 2));
                checks++;
                if (cap_data.size() != exp_data.size() || cap_latency !== 2) begin
                    errors++; $display("[TB] FAIL rand_beats: got %0d lat=%0d, required %0d lat=2",
                                       cap_data.size(), cap_latency, exp_data.size());
                end else foreach (exp_data[i]) begin
                    checks++;
                    if (cap_data[i] !== exp_data[i] || cap_joined[i] !== exp_joined[i] ||
                        cap_last[i] !== exp_last[i] || cap_serial[i] !== ser) begin
                        errors++;
                        $display("[TB] FAIL rand_beat%0d: got %h j=%b l=%b, required %h j=%b l=%b",
                                 i, cap_data[i], cap_joined[i], cap_last[i],
                                 exp_data[i], exp_joined[i], exp_last[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        int n;
        drive_build(make_tuple(32'd40), 32'd3, 1'b1);
        out_ready = 1'b0;
        send_probe(make_tuple(32'd40), 32'd3, 64'd55, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_emit: out_valid=%b, required 1", out_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready_BUILD !== 1'b1 || in_ready_PROBE !== 1'b0 ||
            out_overflow_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_state: got v=%b rb=%b rp=%b ovf=%0d, required 0 1 0 0",
                               out_valid, in_ready_BUILD, in_ready_PROBE, out_overflow_cnt);
        end
        drive_build(make_tuple(32'd41), 32'd3, 1'b1);
        run_probe(make_tuple(32'd40), 32'd3, 64'd56, 1'b1, 0);
        checks++;
        if (cap_data.size() != 1 || cap_joined[0] !== 1'b0 || cap_data[0] !== exp_data[0]) begin
            errors++; $display("[TB] FAIL midreset_old_key: got beats=%0d, required 1 miss beat", cap_data.size());
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        in_data_BUILD = '0; in_hash_BUILD = '0; in_valid_BUILD = 1'b0; in_last_processed_BUILD = 1'b0;
        in_data_PROBE = '0; in_hash_PROBE = '0; in_valid_PROBE = 1'b0; in_last_processed_PROBE = 1'b0;
        in_serialnum = '0;
        test_reset();
        test_basic_join();
        test_duplicates();
        test_miss();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hash_table_v3.md
Name: hash_table_v3

Overview:
- Parametrised BRAM-style hash table for one partition of the partitioned hash join.
- BUILD phase: inserts build tuples into bucket rows selected by the hash.
- PROBE phase: looks up each probe tuple and emits one joined result per key match, or one miss beat when nothing matches.
- Replaces the always-ready stub in the join pipeline, downstream of the partitioner/hasher; runs BUILD → PROBE → BUILD cyclically per partition.

Parameters:
- TUPLE_SIZE, 64: width of build and probe tuples in bits.
- KEY_BITS, 32: key = tuple[KEY_BITS-1:0]; must be ≤ TUPLE_SIZE.
- ROW_BITS, 3: rows (buckets) = 2^ROW_BITS; row index = hash[ROW_BITS-1:0].
- COL_BITS, 1: slots per row = 2^COL_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_ready_BUILD  out  1  build tuple accepted when in_valid_BUILD & in_ready_BUILD
- in_data_BUILD  in  TUPLE_SIZE  build tuple
- in_hash_BUILD  in  32  build hash
- in_valid_BUILD  in  1  build tuple valid
- in_last_processed_BUILD  in  1  qualifies the final build tuple
- in_ready_PROBE  out  1  probe handshake ready
- in_data_PROBE  in  TUPLE_SIZE  probe tuple
- in_hash_PROBE  in  32  probe hash
- in_valid_PROBE  in  1  probe tuple valid
- in_last_processed_PROBE  in  1  qualifies the final probe tuple
- in_serialnum  in  64  probe serial number, returned with every result of that probe
- out_ready  in  1  downstream ready
- out_valid  out  1  result valid
- out_data  out  2*TUPLE_SIZE  {build_tuple, probe_tuple}; build half is 0 on a miss
- out_last_processed  out  1  set on the final beat of the last probe tuple
- out_serialnum  out  64  serial number of the probe producing the beat
- out_was_joined  out  1  1 = match beat, 0 = miss beat
- out_overflow_cnt  out  32  build tuples dropped because their row was full

Behaviour:
- Reset:
  - state = BUILD; all row fill counters = 0; out_overflow_cnt = 0.
  - All out_* = 0; in_ready_BUILD = 1, in_ready_PROBE = 0 in the cycle after reset deasserts.
  - Reset mid-operation aborts any pending result and discards table contents; the data array itself is not cleared.
- Storage:
  - Data array of rows × slots × TUPLE_SIZE.
  - Per-row fill counter, COL_BITS+1 bits wide; slot s is valid iff s < fill[row].
- BUILD state:
  - in_ready_BUILD = 1, in_ready_PROBE = 0.
  - On accept: if fill[row] < 2^COL_BITS, write the tuple to slot fill[row] and increment fill[row].
  - Otherwise drop the tuple and increment out_overflow_cnt, saturating at 2^32-1.
  - An accepted tuple with in_last_processed_BUILD = 1 is inserted normally, then the block moves to P_IDLE next cycle.
- P_IDLE:
  - in_ready_PROBE = 1.
  - On accept: latch the probe tuple, serialnum, last flag and row index; go to P_READ.
- P_READ (1 cycle, ready low):
  - Register the row contents.
  - Form a match vector: bit s = (s < fill) && key(slot s) == key(probe).
  - Go to P_EMIT.
- P_EMIT:
  - Match vector non-zero: present the lowest set slot, out_was_joined = 1, out_data = {slot tuple, probe tuple}.
  - On out_valid & out_ready, clear that bit and present the next match in the following cycle.
  - Match vector zero on entry: present a single miss beat, out_was_joined = 0.
  - out_data, out_serialnum and out_was_joined stay stable while out_valid & !out_ready.
  - After the final beat is accepted: return to P_IDLE, or to BUILD if the latched last flag is set.
  - Returning to BUILD clears every fill counter in the same edge.
- out_last_processed = latched probe last flag AND (this is the final beat). It is 0 on all other beats.
- Duplicate build keys are all stored and all reported.
- Minimum probe latency: accept → first out_valid in 2 cycles. Throughput is one probe per (2 + beats) cycles.
- The handshake on the input port of the inactive phase is ignored: its ready is 0, so no accept can occur.

Test Plan:
- Build keys 5 (hash 1), 9 (hash 1), 12 (hash 4) with last on 12; probe key 9 hash 1, serial 7 → exactly one beat: was_joined = 1, data = {tuple9, probe}, serialnum = 7.
- Build two tuples with key 3 in row 2; probe key 3 → two consecutive joined beats, slot 0 first, then slot 1.
- Probe key 77 hash 6 into an empty row → one beat: was_joined = 0, upper 64 bits = 0.
- Build three tuples into row 0 with COL_BITS = 1 → third tuple dropped, out_overflow_cnt = 1; a probe matching the third key misses.
- Hold out_ready = 0 for 5 cycles during a 2-match emit → out_valid and out_data stable; both beats are delivered once out_ready rises. Last probe sets out_last_processed only on the second beat, then in_ready_BUILD = 1 and the fill counters read 0.
- Assert reset during P_EMIT → next cycle out_valid = 0, state = BUILD, and a subsequent probe of the old key misses.
